// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Package : spi_ram_pkg
// Desc    : Shared state encoding, frame commands and frame width for spi_ram_slave.
// Rev     : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WRITE     = 3'd1,
      CHK_CMD   = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4
   } state_e;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam int FRAME_W = 10;

endpackage
`default_nettype wire

// File: rtl/spi_ram_mem.sv
`default_nettype none
// ============================================================================
// Module : spi_ram_mem
// Desc   : Single-port RAM decoding received frames into address/data operations.
// Rev    : 1.0 - initial release
// ============================================================================
module spi_ram_mem
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [FRAME_W-1:0]   din,
   input  logic                 rx_valid,
   output logic [ADDR_SIZE-1:0] dout,
   output logic                 tx_valid
);

   logic [ADDR_SIZE-1:0] r_mem [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] r_wr_addr;
   logic [ADDR_SIZE-1:0] r_rd_addr;
   logic                 w_wr_ok;
   logic                 w_rd_ok;
   logic [1:0]           w_cmd;
   logic [ADDR_SIZE-1:0] w_payload;

   assign w_cmd     = din[FRAME_W-1 -: 2];
   assign w_payload = din[ADDR_SIZE-1:0];

   // Addresses beyond the populated depth are neither written nor read.
   generate
      if (MEM_DEPTH >= (1 << ADDR_SIZE)) begin : g_full_range
         assign w_wr_ok = 1'b1;
         assign w_rd_ok = 1'b1;
      end else begin : g_part_range
         assign w_wr_ok = (r_wr_addr < ADDR_SIZE'(MEM_DEPTH));
         assign w_rd_ok = (r_rd_addr < ADDR_SIZE'(MEM_DEPTH));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst && rx_valid && (w_cmd == CMD_WR_DATA) && w_wr_ok) begin
         r_mem[r_wr_addr] <= w_payload;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_addr <= '0;
         r_rd_addr <= '0;
         dout      <= '0;
         tx_valid  <= 1'b0;
      end else begin
         tx_valid <= 1'b0;
         if (rx_valid) begin
            case (w_cmd)
               CMD_WR_ADDR: r_wr_addr <= w_payload;
               CMD_RD_ADDR: r_rd_addr <= w_payload;
               CMD_RD_DATA: begin
                  dout     <= w_rd_ok ? r_mem[r_rd_addr] : '0;
                  tx_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/spi_ram_slave.sv
`default_nettype none
// ============================================================================
// Module : spi_ram_slave
// Desc   : SPI slave front-end (10-bit frames in, 8-bit read data out) over a RAM.
// Rev    : 1.0 - initial release
// ============================================================================
module spi_ram_slave
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO
);

   localparam int c_CNT_W    = $clog2(FRAME_W);
   localparam int c_TX_CNT_W = $clog2(ADDR_SIZE);

   state_e                 r_state;
   logic [c_CNT_W-1:0]     r_bit_cnt;
   logic [FRAME_W-2:0]     r_rx_shift;
   logic [FRAME_W-1:0]     r_rx_data;
   logic                   r_rx_valid;
   logic                   r_rd_addr_seen;
   logic [ADDR_SIZE-2:0]   r_tx_shift;
   logic [c_TX_CNT_W-1:0]  r_tx_cnt;

   logic [FRAME_W-1:0]     w_frame;
   logic                   w_last_bit;
   logic [ADDR_SIZE-1:0]   w_tx_data;
   logic                   w_tx_valid;
   logic                   w_in_rd_data;

   assign w_frame      = {r_rx_shift, MOSI};
   assign w_last_bit   = (r_bit_cnt == c_CNT_W'(FRAME_W - 1));
   assign w_in_rd_data = (r_state == READ_DATA);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_bit_cnt      <= '0;
         r_rx_shift     <= '0;
         r_rx_data      <= '0;
         r_rx_valid     <= 1'b0;
         r_rd_addr_seen <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (SS_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_state   <= CHK_CMD;
                  r_bit_cnt <= '0;
               end
               // The command MSB picks the target state and is also the first frame bit.
               CHK_CMD: begin
                  r_rx_shift <= w_frame[FRAME_W-2:0];
                  r_bit_cnt  <= c_CNT_W'(1);
                  if (!MOSI)
                     r_state <= WRITE;
                  else if (r_rd_addr_seen)
                     r_state <= READ_DATA;
                  else
                     r_state <= READ_ADD;
               end
               WRITE, READ_ADD, READ_DATA: begin
                  r_rx_shift <= w_frame[FRAME_W-2:0];
                  if (w_last_bit) begin
                     r_bit_cnt  <= '0;
                     r_rx_data  <= w_frame;
                     // A read-data command arriving in WRITE never reaches the RAM.
                     r_rx_valid <= !((r_state == WRITE) &&
                                     (w_frame[FRAME_W-1 -: 2] == CMD_RD_DATA));
                     if (r_state == READ_ADD)
                        r_rd_addr_seen <= 1'b1;
                     else if (r_state == READ_DATA)
                        r_rd_addr_seen <= 1'b0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   // Read data leaves MSB first; the shifter keeps running outside READ_DATA but MISO stays low.
   always_ff @(posedge clk) begin
      if (rst) begin
         MISO       <= 1'b0;
         r_tx_shift <= '0;
         r_tx_cnt   <= '0;
      end else if (w_tx_valid) begin
         MISO       <= w_in_rd_data & w_tx_data[ADDR_SIZE-1];
         r_tx_shift <= w_tx_data[ADDR_SIZE-2:0];
         r_tx_cnt   <= c_TX_CNT_W'(ADDR_SIZE - 1);
      end else if (r_tx_cnt != '0) begin
         MISO       <= w_in_rd_data & r_tx_shift[ADDR_SIZE-2];
         r_tx_shift <= {r_tx_shift[ADDR_SIZE-3:0], 1'b0};
         r_tx_cnt   <= r_tx_cnt - c_TX_CNT_W'(1);
      end else begin
         MISO <= 1'b0;
      end
   end

   spi_ram_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_SIZE (ADDR_SIZE)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .din      (r_rx_data),
      .rx_valid (r_rx_valid),
      .dout     (w_tx_data),
      .tx_valid (w_tx_valid)
   );

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for spi_ram_slave: directed scenarios, then random bursts checked against a frame-level model.
module tb_spi_ram_slave;

   localparam int S_IDLE  = 0;
   localparam int S_WRITE = 1;
   localparam int S_CHK   = 2;
   localparam int S_RADD  = 3;
   localparam int S_RDATA = 4;

   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic SS_n = 1'b1;
   logic MOSI = 1'b0;
   logic MISO;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_mem [256];
   logic [7:0] m_wr_addr = 8'h00;
   logic [7:0] m_rd_addr = 8'h00;
   logic       m_seen    = 1'b0;
   int         st_hist[$];
   logic [9:0] fq[$];
   logic [7:0] obs_tx;

   spi_ram_slave #(
      .MEM_DEPTH (256),
      .ADDR_SIZE (8)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .SS_n (SS_n),
      .MOSI (MOSI),
      .MISO (MISO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge with the given inputs, then check state, MISO and the delayed-MISO invariant.
   task automatic step(input logic ss, input logic mosi, input int exp_state,
                       input logic exp_miso, input string tag);
      SS_n = ss;
      MOSI = mosi;
      @(posedge clk);
      #1;
      chk({tag, "/state"}, 32'(dut.r_state), 32'(exp_state));
      chk({tag, "/miso"}, 32'(MISO), 32'(exp_miso));
      st_hist.push_back(exp_state);
      if (st_hist.size() == 4) begin
         if (st_hist[0] != S_RDATA) chk({tag, "/inv3"}, 32'(MISO), 32'd0);
         void'(st_hist.pop_front());
      end
   endtask

   task automatic do_reset(input logic ss);
      rst  = 1'b1;
      SS_n = ss;
      MOSI = 1'($urandom);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset/state", 32'(dut.r_state), 32'(S_IDLE));
      chk("reset/miso", 32'(MISO), 32'd0);
      m_wr_addr = 8'h00;
      m_rd_addr = 8'h00;
      m_seen    = 1'b0;
      st_hist.delete();
      st_hist.push_back(S_IDLE);
   endtask

   task automatic one(input logic [9:0] f);
      fq.delete();
      fq.push_back(f);
   endtask

   // Keeps SS_n low for all frames in fq plus 'pad' extra bits, then raises it.
   task automatic burst(input int pad, input logic [9:0] pad_bits, input string tag);
      logic       bits[$];
      logic       em[];
      int         n;
      int         s;
      logic [9:0] f;
      logic [7:0] d;
      foreach (fq[k]) for (int b = 9; b >= 0; b--) bits.push_back(fq[k][b]);
      for (int b = 9; b > 9 - pad; b--) bits.push_back(pad_bits[b]);
      n  = bits.size();
      em = new[n + 1];
      foreach (em[i]) em[i] = 1'b0;
      s = (bits[0] == 1'b0) ? S_WRITE : (m_seen ? S_RDATA : S_RADD);
      for (int k = 0; k < fq.size(); k++) begin
         f = fq[k];
         if (s == S_RADD) m_seen = 1'b1;
         else if (s == S_RDATA) m_seen = 1'b0;
         case (f[9:8])
            2'b00: m_wr_addr = f[7:0];
            2'b01: m_mem[m_wr_addr] = f[7:0];
            2'b10: m_rd_addr = f[7:0];
            default: begin
               d = m_mem[m_rd_addr];
               // Frame k ends at edge 10k+10; its data shows on MISO from edge 10k+12.
               if (s == S_RDATA)
                  for (int j = 0; j < 8; j++) em[10 * k + 12 + j] = d[7 - j];
            end
         endcase
      end
      step(1'b0, 1'($urandom), S_CHK, 1'b0, tag);
      obs_tx = 8'h00;
      for (int e = 1; e <= n; e++) begin
         step(1'b0, bits[e - 1], s, em[e], tag);
         if (e > n - 8) obs_tx = {obs_tx[6:0], MISO};
      end
      step(1'b1, 1'($urandom), S_IDLE, 1'b0, tag);
   endtask

   initial begin
      foreach (m_mem[i]) m_mem[i] = 8'h00;

      do_reset(1'b1);

      one(10'h010); burst(9, 10'($urandom), "wr_addr_10");
      one(10'h1A5); burst(9, 10'($urandom), "wr_data_a5");
      one(10'h210); burst(9, 10'($urandom), "rd_addr_10");
      one(10'h300); burst(9, 10'($urandom), "rd_data_10");
      chk("rd_10_value", 32'(obs_tx), 32'h0A5);

      fq.delete();  burst(5, 10'h13C, "partial_3c");
      step(1'b1, 1'b0, S_IDLE, 1'b0, "gap");
      one(10'h210); burst(9, 10'($urandom), "rd_addr_10b");
      one(10'h300); burst(9, 10'($urandom), "rd_data_10b");
      chk("rd_10_after_partial", 32'(obs_tx), 32'h0A5);

      do_reset(1'b0);
      one(10'h2FF); burst(9, 10'($urandom), "rd_addr_ff_after_rst");
      fq.delete();
      fq.push_back(10'h0FF);
      fq.push_back(10'h15A);
      burst(9, 10'($urandom), "wr_ff_5a");
      one(10'h300); burst(9, 10'($urandom), "rd_data_ff");
      chk("rd_ff_value", 32'(obs_tx), 32'h05A);

      fq.delete();
      for (int a = 0; a < 256; a++) begin
         fq.push_back({2'b00, 8'(a)});
         fq.push_back({2'b01, 8'($urandom)});
      end
      burst(9, 10'($urandom), "fill");

      for (int b = 0; b < 60; b++) begin
         int nf;
         int ng;
         nf = $urandom_range(0, 4);
         fq.delete();
         for (int k = 0; k < nf; k++) fq.push_back({2'($urandom_range(0, 3)), 8'($urandom)});
         burst((nf == 0) ? $urandom_range(1, 9) : 9, 10'($urandom), "rnd");
         ng = $urandom_range(0, 2);
         for (int g = 0; g < ng; g++) step(1'b1, 1'($urandom), S_IDLE, 1'b0, "rnd_gap");
         if ($urandom_range(0, 15) == 0) do_reset(1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
